seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_gen_shreg.sv | 55 +++++
 rtl/seq_gen.sv | 123 ++++++++++++
 tb/tb_seq_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types, default sizes and the length-normalisation helper for seq_gen.
package seq_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefLenw  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  // A length of 0 or anything longer than the register means "send everything".
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Pattern register plus down-counting bit index; o is the registered serial bit.
module seq_gen_shreg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,     // capture data/len and present bit len-1
  input  logic             restart,  // present bit len-1 of the captured pattern
  input  logic             step,     // present the next lower bit
  input  logic             clear,    // drive o low
  input  logic [WIDTH-1:0] data,
  input  logic [LENW-1:0]  len,      // already normalised to 1..WIDTH
  output logic             o,
  output logic             last      // bit 0 is on o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] data_q;
  logic [IdxW-1:0]  top_q;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW-1:0]  top_new;
  logic             o_q;

  assign top_new = IdxW'(len - LENW'(1));

  // Load/restart start from the top bit; index only ever walks down within 0..len-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      top_q  <= '0;
      idx_q  <= '0;
      o_q    <= 1'b0;
    end else if (load) begin
      data_q <= data;
      top_q  <= top_new;
      idx_q  <= top_new;
      o_q    <= data[top_new];
    end else if (restart) begin
      idx_q <= top_q;
      o_q   <= data_q[top_q];
    end else if (step) begin
      idx_q <= idx_q - IdxW'(1);
      o_q   <= data_q[idx_q - IdxW'(1)];
    end else if (clear) begin
      idx_q <= '0;
      o_q   <= 1'b0;
    end
  end

  assign o    = o_q;
  assign last = (idx_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: accepts a pattern, shifts it out MSB-first, repeats with gaps.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LENW  = DefLenw
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LENW-1:0]  load_len,
  input  logic [3:0]       load_rep,
  input  logic             abort,
  output logic             O,
  output logic             busy,
  output logic             done
);

  state_e          state_q, state_d;
  logic [3:0]      rep_q, rep_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            sr_load, sr_restart, sr_step, sr_clear;
  logic            sr_last;
  logic [LENW-1:0] len_eff;

  assign len_eff = LENW'(norm_len(32'(load_len), WIDTH));

  seq_gen_shreg #(
    .WIDTH (WIDTH),
    .LENW  (LENW)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sr_load),
    .restart (sr_restart),
    .step    (sr_step),
    .clear   (sr_clear),
    .data    (load_data),
    .len     (len_eff),
    .o       (O),
    .last    (sr_last)
  );

  // Next state, repetition count, shifter controls and registered status flags.
  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    done_d     = 1'b0;
    sr_load    = 1'b0;
    sr_restart = 1'b0;
    sr_step    = 1'b0;
    sr_clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort wins over a simultaneous load
        if (load_valid && !abort) begin
          state_d = StShift;
          rep_d   = load_rep;
          sr_load = 1'b1;
        end
      end
      StShift: begin
        if (abort) begin
          state_d  = StIdle;
          rep_d    = '0;
          sr_clear = 1'b1;
        end else if (!sr_last) begin
          sr_step = 1'b1;
        end else if (rep_q != '0) begin
          state_d  = StGap;
          rep_d    = rep_q - 4'd1;
          sr_clear = 1'b1;
        end else begin
          state_d  = StIdle;
          done_d   = 1'b1;
          sr_clear = 1'b1;
        end
      end
      StGap: begin
        if (abort) begin
          state_d  = StIdle;
          rep_d    = '0;
          sr_clear = 1'b1;
        end else begin
          state_d    = StShift;
          sr_restart = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        sr_clear = 1'b1;
      end
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  // State and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rep_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen with a 1001 sequence detector on the serial output.
module tb_seq_gen;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LENW  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             load_valid = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [LENW-1:0]  load_len = '0;
  logic [3:0]       load_rep = '0;
  logic             load_ready, O, busy, done;

  int total = 0;
  int bad = 0;

  seq_gen #(
    .WIDTH (WIDTH),
    .LENW  (LENW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_rep   (load_rep),
    .abort      (abort),
    .O          (O),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Loopback sequence detector: F pulses one cycle after 1,0,0,1 appears on O.
  logic [3:0] hist;
  logic       f;
  int         f_cnt = 0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      f    <= 1'b0;
    end else begin
      hist <= {hist[2:0], O};
      f    <= ({hist[2:0], O} == 4'b1001);
    end
  end

  always @(negedge clk) if (f) f_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    abort      = 1'b0;
    repeat (n) tick();
  endtask

  // Offer a pattern for one edge; returns in the first cycle after that edge.
  task automatic drive_load(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = l;
    load_rep   = r;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_hold: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
  endtask

  task automatic test_basic();
    logic [31:0] bits;
    int f0;
    bits = 32'b1001;
    idle(4);
    f0 = f_cnt;
    drive_load(16'h0009, 5'd4, 4'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits[3-i], 3'b100}) begin
        bad++;
        $display("FAIL basic_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits[3-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL basic_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL basic_idle: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
    total++;
    if (f_cnt - f0 !== 1) begin
      bad++;
      $display("FAIL basic_detect: got %0d want %0d", f_cnt - f0, 1);
    end
  endtask

  // Repeated frames: 101 x3 with a single zero gap between frames.
  task automatic test_reps();
    logic [31:0] bits;
    int f0;
    int done_seen;
    bits = 32'b10101010101;
    done_seen = 0;
    idle(4);
    f0 = f_cnt;
    drive_load(16'h0005, 5'd3, 4'd2);
    for (int i = 0; i < 11; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits[10-i], 3'b100}) begin
        bad++;
        $display("FAIL reps_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits[10-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL reps_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL reps_extra_done: got %0d want %0d", done_seen, 0);
    end
    total++;
    if (f_cnt - f0 !== 0) begin
      bad++;
      $display("FAIL reps_detect: got %0d want %0d", f_cnt - f0, 0);
    end
  endtask

  // len=0 means the full 16 bits.
  task automatic test_len0();
    logic [31:0] bits;
    int f0;
    bits = 32'h8001;
    idle(4);
    f0 = f_cnt;
    drive_load(16'h8001, 5'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits[15-i], 3'b100}) begin
        bad++;
        $display("FAIL len0_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits[15-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL len0_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
    total++;
    if (f_cnt - f0 !== 0) begin
      bad++;
      $display("FAIL len0_detect: got %0d want %0d", f_cnt - f0, 0);
    end
  endtask

  // len=1 with repeats: only bit 0 is ever sent.
  task automatic test_len1();
    logic [31:0] bits;
    bits = 32'b10101;
    idle(4);
    drive_load(16'hFFF1, 5'd1, 4'd2);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits[4-i], 3'b100}) begin
        bad++;
        $display("FAIL len1_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits[4-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL len1_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    int f0;
    done_seen = 0;
    idle(4);
    f0 = f_cnt;
    drive_load(16'h00FF, 5'd8, 4'd0);
    tick();
    tick();
    total++;
    if ({O, busy, done, load_ready} !== 4'b1100) begin
      bad++;
      $display("FAIL abort_pre: got %b want %b", {O, busy, done, load_ready}, 4'b1100);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL abort_post: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || O) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d want %0d", done_seen, 0);
    end
    // abort together with a load in IDLE: load is dropped
    load_valid = 1'b1;
    abort      = 1'b1;
    tick();
    load_valid = 1'b0;
    abort      = 1'b0;
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL abort_idle_load: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
    tick();
    total++;
    if (f_cnt - f0 !== 0) begin
      bad++;
      $display("FAIL abort_detect: got %0d want %0d", f_cnt - f0, 0);
    end
  endtask

  task automatic test_reset_gap();
    logic [31:0] bits;
    int f0;
    bits = 32'b1001;
    idle(4);
    drive_load(16'h0005, 5'd3, 4'd1);
    tick();
    tick();
    tick();
    total++;
    if ({O, busy, done, load_ready} !== 4'b0100) begin
      bad++;
      $display("FAIL rgap_in_gap: got %b want %b", {O, busy, done, load_ready}, 4'b0100);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({O, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL rgap_async: got %b want %b", {O, busy, done}, 3'b000);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if ({O, busy, done, load_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL rgap_after: got %b want %b", {O, busy, done, load_ready}, 4'b0001);
    end
    idle(3);
    f0 = f_cnt;
    drive_load(16'h0009, 5'd4, 4'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits[3-i], 3'b100}) begin
        bad++;
        $display("FAIL rgap_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits[3-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL rgap_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
    total++;
    if (f_cnt - f0 !== 1) begin
      bad++;
      $display("FAIL rgap_detect: got %0d want %0d", f_cnt - f0, 1);
    end
  endtask

  // load_valid held high: data changed mid-frame must not disturb frame A;
  // frame B is taken in A's done cycle.
  task automatic test_back_to_back();
    logic [31:0] bits_a;
    logic [31:0] bits_b;
    int f0;
    bits_a = 32'b1001;
    bits_b = 32'b10011;
    idle(4);
    f0 = f_cnt;
    load_valid = 1'b1;
    load_data  = 16'h0009;
    load_len   = 5'd4;
    load_rep   = 4'd0;
    tick();
    load_data = 16'h0013;
    load_len  = 5'd5;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits_a[3-i], 3'b100}) begin
        bad++;
        $display("FAIL b2b_a_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits_a[3-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_a_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({O, busy, done, load_ready} !== {bits_b[4-i], 3'b100}) begin
        bad++;
        $display("FAIL b2b_b_bit%0d: got %b want %b", i, {O, busy, done, load_ready},
                 {bits_b[4-i], 3'b100});
      end
      tick();
    end
    total++;
    if ({O, busy, done, load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_b_done: got %b want %b", {O, busy, done, load_ready}, 4'b0011);
    end
    tick();
    total++;
    if (f_cnt - f0 !== 2) begin
      bad++;
      $display("FAIL b2b_detect: got %0d want %0d", f_cnt - f0, 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reps();
    test_len0();
    test_len1();
    test_abort();
    test_reset_gap();
    test_back_to_back();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
